// File: rtl/rom_arb_pkg.sv
// Shared types and helpers for the ROM access arbiter.
package rom_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPT, ACK} arb_state_t;

  localparam int ARB_LAT = 3;

  function automatic logic [2:0] onehot2idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rom_arb_pick.sv
// Combinational requester selection: fixed priority, or round-robin from ptr
// when ROM_ARB_RR_EN is defined.
module rom_arb_pick
  import rom_arb_pkg::*;
#(
  parameter int NR = 2,
  parameter int IW = 1
) (
  input  logic [NR-1:0] req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_valid
);

  logic [7:0] rot;
  logic [7:0] iso;
  logic [2:0] off;

`ifdef ROM_ARB_RR_EN
  logic [3:0] sum;

  // Rotate so the pointer index sits at bit 0, pick lowest, rotate back.
  always_comb begin
    int j;
    rot = '0;
    for (int i = 0; i < NR; i++) begin
      j = i + int'(ptr);
      if (j >= NR) j = j - NR;
      rot[i] = req[j];
    end
    iso = rot & (~rot + 8'd1);
    off = onehot2idx(iso);
    sum = 4'(off) + 4'(ptr);
    if (sum >= 4'(NR)) sum = sum - 4'(NR);
    gnt_idx = IW'(sum);
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    rot = 8'(req);
    iso = rot & (~rot + 8'd1);
    off = onehot2idx(iso);
    gnt_idx = IW'(off);
  end
`endif

  assign gnt_valid = |req;

endmodule

// File: rtl/rom_access_arbiter.sv
// Shares one registered-read ROM port between NR req/ack requesters.
// Define ROM_ARB_RR_EN for round-robin arbitration; default is fixed priority.
module rom_access_arbiter
  import rom_arb_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 14,
  parameter int NR = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NR-1:0]    req,
  input  logic [NR*AW-1:0] addr,
  output logic [NR-1:0]    ack,
  output logic [DW-1:0]    rdata,
  output logic             rom_ce,
  output logic [AW-1:0]    rom_a,
  input  logic [DW-1:0]    rom_d,
  output logic             busy
);

  localparam int IW = $clog2(NR);

  arb_state_t    state;
  logic [IW-1:0] grant;
  logic [IW-1:0] ptr;
  logic [IW-1:0] gnt_idx;
  logic          gnt_valid;
  logic [AW-1:0] addr_sel;

`ifdef ROM_ARB_RR_EN
  logic [IW-1:0] ptr_q;
  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  rom_arb_pick #(.NR(NR), .IW(IW)) u_pick (
    .req       (req),
    .ptr       (ptr),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  always_comb begin
    addr_sel = '0;
    for (int i = 0; i < NR; i++) begin
      if (gnt_idx == IW'(i)) addr_sel = addr[i*AW +: AW];
    end
  end

  // Fixed 4-cycle transaction; an abandoned read still walks through ACK.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      grant  <= '0;
      ack    <= '0;
      rdata  <= '0;
      rom_ce <= 1'b0;
      rom_a  <= '0;
      busy   <= 1'b0;
`ifdef ROM_ARB_RR_EN
      ptr_q  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            grant  <= gnt_idx;
            rom_a  <= addr_sel;
            rom_ce <= 1'b1;
            busy   <= 1'b1;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          rom_ce <= 1'b0;
          state  <= CAPT;
        end
        CAPT: begin
          rdata <= rom_d;
          if (req[grant]) begin
            ack <= NR'(1) << grant;
`ifdef ROM_ARB_RR_EN
            ptr_q <= (grant == IW'(NR - 1)) ? '0 : grant + 1'b1;
`endif
          end
          state <= ACK;
        end
        ACK: begin
          ack   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_access_arbiter.sv
// Self-checking bench for rom_access_arbiter: directed scenarios plus random
// requester traffic against a transaction-schedule reference model.
module tb_rom_access_arbiter;
  import rom_arb_pkg::*;

  localparam int DW = 8;
  localparam int AW = 14;
  localparam int NR = 2;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [NR-1:0]    req = '0;
  logic [NR*AW-1:0] addr = '0;
  logic [NR-1:0]    ack;
  logic [DW-1:0]    rdata;
  logic             rom_ce;
  logic [AW-1:0]    rom_a;
  logic [DW-1:0]    rom_d = '0;
  logic             busy;

  int n_vec = 0;
  int n_err = 0;

  rom_access_arbiter #(.DW(DW), .AW(AW), .NR(NR)) dut (
    .clock  (clock),
    .reset  (reset),
    .req    (req),
    .addr   (addr),
    .ack    (ack),
    .rdata  (rdata),
    .rom_ce (rom_ce),
    .rom_a  (rom_a),
    .rom_d  (rom_d),
    .busy   (busy)
  );

  always #5 clock = ~clock;

  // ROM model: registered read, d[a] = a[7:0] ^ 8'h5A
  always @(posedge clock) if (rom_ce) rom_d <= rom_a[7:0] ^ 8'h5A;

  // Reference model: each transaction is a schedule keyed on its start edge t0.
  int            edge_n = 0;
  int            t0 = -100;
  int            free_at = 0;
  int            m_w = 0;
  int            m_ptr = 0;
  logic [AW-1:0] m_a = '0;
  logic [DW-1:0] m_rdata = '0;
  bit            m_acked = 1'b0;
  logic          prev_ce = 1'b0;

  function automatic int ref_pick(input logic [NR-1:0] r, input int p);
    for (int k = 0; k < NR; k++) begin
      if (r[(p + k) % NR]) return (p + k) % NR;
    end
    return 0;
  endfunction

  always @(posedge clock) begin
    edge_n++;
    if (reset) begin
      t0 = -100; free_at = edge_n + 1; m_a = '0; m_rdata = '0;
      m_acked = 1'b0; m_ptr = 0;
    end else begin
      if (edge_n == t0 + 2) begin
        m_rdata = m_a[7:0] ^ 8'h5A;
        m_acked = req[m_w];
`ifdef ROM_ARB_RR_EN
        if (m_acked) m_ptr = (m_w + 1) % NR;
`endif
      end
      if (edge_n >= free_at && req != '0) begin
        m_w = ref_pick(req, m_ptr);
        m_a = addr[m_w*AW +: AW];
        t0 = edge_n;
        free_at = edge_n + 4;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  task automatic step();
    logic [NR-1:0] exp_ack;
    @(negedge clock);
    exp_ack = (edge_n == t0 + 2 && m_acked) ? NR'(1) << m_w : '0;
    chk("ack", 32'(ack), 32'(exp_ack));
    chk("rdata", 32'(rdata), 32'(m_rdata));
    chk("rom_ce", 32'(rom_ce), 32'(edge_n == t0));
    chk("rom_a", 32'(rom_a), 32'(m_a));
    chk("busy", 32'(busy), 32'(edge_n >= t0 && edge_n <= t0 + 2));
    chk("ack_onehot0", 32'($onehot0(ack)), 32'd1);
    chk("ce_b2b", 32'(rom_ce & prev_ce), 32'd0);
    prev_ce = rom_ce;
  endtask

  task automatic idle(input int n);
    req = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int n0, n1, last, prev_idx, idx, k, seen;
    logic [7:0] t3_exp [3];
    t3_exp = '{8'h5A, 8'h5B, 8'h58};

    step();
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;

    // 1: single read
    addr[0 +: AW] = 14'h0123; req = 2'b01; seen = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (ack[0]) begin
        chk("t1_rdata", 32'(rdata), 32'h79);
        chk("t1_lat", 32'(c + 1), 32'(ARB_LAT));
        req[0] = 1'b0; seen++;
      end
    end
    chk("t1_seen", 32'(seen), 32'd1);
    idle(3);

    // 2: contention with both requests held
    addr[0 +: AW] = 14'h0010; addr[AW +: AW] = 14'h0020; req = 2'b11;
    n0 = 0; n1 = 0; last = -1; prev_idx = -1;
    for (int c = 0; c < 24; c++) begin
      step();
      if (ack != '0) begin
        idx = ack[1] ? 1 : 0;
        if (idx == 0) begin n0++; chk("t2_rdata0", 32'(rdata), 32'h4A); end
        else begin n1++; chk("t2_rdata1", 32'(rdata), 32'h7A); end
        if (last >= 0) chk("t2_gap", 32'(c - last), 32'd4);
`ifdef ROM_ARB_RR_EN
        if (prev_idx >= 0) chk("t2_alt", 32'(idx), 32'(1 - prev_idx));
`endif
        last = c; prev_idx = idx;
      end
    end
`ifdef ROM_ARB_RR_EN
    chk("t2_n1", 32'(n1 >= 2), 32'd1);
`else
    chk("t2_n1", 32'(n1), 32'd0);
`endif
    chk("t2_n0", 32'(n0 >= 2), 32'd1);
    idle(5);

    // 3: back-to-back reads on requester 1 with stepped address
    addr[AW +: AW] = 14'h0000; req = 2'b10; k = 0; last = -1;
    for (int c = 0; c < 20; c++) begin
      step();
      if (ack[1] && k < 3) begin
        chk("t3_rdata", 32'(rdata), 32'(t3_exp[k]));
        if (last >= 0) chk("t3_gap", 32'(c - last), 32'd4);
        last = c; k++;
        addr[AW +: AW] = AW'(k);
        if (k == 3) req[1] = 1'b0;
      end
    end
    chk("t3_count", 32'(k), 32'd3);
    idle(4);

    // 4: requester 0 abandons in CAPT, requester 1 follows
    addr[0 +: AW] = 14'h0100; req = 2'b01;
    step(); step();
    req[0] = 1'b0; addr[AW +: AW] = 14'h0200; req[1] = 1'b1;
    step();
    chk("t4_noack", 32'(ack), 32'd0);
    chk("t4_rdata", 32'(rdata), 32'h5A);
    step();
    chk("t4_busy", 32'(busy), 32'd0);
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (ack[1]) begin chk("t4_rdata1", 32'(rdata), 32'h5A); req[1] = 1'b0; seen++; end
    end
    chk("t4_seen", 32'(seen), 32'd1);
    idle(3);

    // 5: reset during ISSUE
    addr[0 +: AW] = 14'h0345; req = 2'b01;
    step();
    reset = 1'b1;
    step();
    chk("t5_ack", 32'(ack), 32'd0);
    chk("t5_ce", 32'(rom_ce), 32'd0);
    chk("t5_rdata", 32'(rdata), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    reset = 1'b0; seen = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (ack[0]) begin
        chk("t5_lat", 32'(c + 1), 32'(ARB_LAT));
        chk("t5_rdata1", 32'(rdata), 32'h1F);
        req[0] = 1'b0; seen++;
      end
    end
    chk("t5_seen", 32'(seen), 32'd1);
    idle(3);

    // random requester traffic with occasional abandon and reset
    for (int c = 0; c < 3000; c++) begin
      step();
      reset = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < NR; i++) begin
        if (req[i] && ack[i]) begin
          req[i] = 1'b0;
          if ($urandom_range(0, 3) == 0) begin
            addr[i*AW +: AW] = AW'($urandom); req[i] = 1'b1;
          end
        end else if (!req[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            addr[i*AW +: AW] = AW'($urandom); req[i] = 1'b1;
          end
        end else if ($urandom_range(0, 19) == 0) begin
          req[i] = 1'b0;
        end
      end
    end
    reset = 1'b0;
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
